xbus_slaveif: RTL and testbench

//  Target-side bridge between the PLB slave IPIF and an XBUS slave. Turns one IPIF

---
 rtl/xbus_slaveif_pkg.sv | 16 +
 rtl/xbus_wdog.sv | 35 +++
 rtl/xbus_slaveif.sv | 124 ++++++++++++
 tb/tb_xbus_slaveif.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbus_slaveif_pkg.sv
// Shared definitions for the XBUS slave bridge: 8-bit FSM encodings and address helpers.
package xbus_slaveif_pkg;

  typedef enum logic [7:0] {
    StIdle = 8'h10,
    StReq  = 8'h11,
    StAck  = 8'h12,
    StGap  = 8'h13
  } xbs_state_e;

  // IPIF byte address to XBUS word address
  function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/xbus_wdog.sv
// REQ-phase watchdog: counts enabled cycles, flags expiry on the last allowed cycle.
module xbus_wdog #(
  parameter int unsigned Cycles = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Cycles) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign expired_o = en_i && (cnt_q == CntW'(Cycles - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/xbus_slaveif.sv
// PLB IPIF to XBUS slave bridge: one single-beat access becomes one XBUS transaction.
// Define XBUS_SLAVEIF_TIMEOUT_EN to add a REQ watchdog that forces an error completion.
module xbus_slaveif
  import xbus_slaveif_pkg::*;
#(
  parameter int unsigned C_DWIDTH         = 32,
  parameter int unsigned C_TIMEOUT_CYCLES = 256,
  parameter logic [31:0] C_ERR_DATA       = 32'h0
) (
  input  logic                Bus2IP_Clk,
  input  logic                Bus2IP_Reset,
  input  logic                Bus2IP_CS,
  input  logic                Bus2IP_RNW,
  input  logic [31:0]         Bus2IP_Addr,
  input  logic [C_DWIDTH-1:0] Bus2IP_Data,
  input  logic [3:0]          Bus2IP_BE,
  output logic [C_DWIDTH-1:0] IP2Bus_Data,
  output logic                IP2Bus_RdAck,
  output logic                IP2Bus_WrAck,
  output logic                IP2Bus_Error,
  output logic                xbs_select,
  output logic [31:0]         xbs_addr,
  output logic [C_DWIDTH-1:0] xbs_data,
  output logic                xbs_rnw,
  output logic [3:0]          xbs_be,
  input  logic                sl_ack,
  input  logic [C_DWIDTH-1:0] sl_data
);

  xbs_state_e            state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [C_DWIDTH-1:0]   wdata_q, wdata_d;
  logic [C_DWIDTH-1:0]   rdata_q, rdata_d;
  logic [3:0]            be_q, be_d;
  logic                  rnw_q, rnw_d;
  logic                  err_q, err_d;
  logic                  expired;
  logic                  in_ack;

`ifdef XBUS_SLAVEIF_TIMEOUT_EN
  xbus_wdog #(
    .Cycles (C_TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i     (Bus2IP_Clk),
    .rst_i     (Bus2IP_Reset),
    .clr_i     (state_q != StReq),
    .en_i      (state_q == StReq),
    .expired_o (expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^C_TIMEOUT_CYCLES;
  assign expired    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    rnw_d   = rnw_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (Bus2IP_CS) begin
          addr_d  = byte_to_word(Bus2IP_Addr);
          wdata_d = Bus2IP_Data;
          be_d    = Bus2IP_BE;
          rnw_d   = Bus2IP_RNW;
          err_d   = 1'b0;
          state_d = StReq;
        end
      end
      StReq: begin
        // A real ack beats a watchdog expiry in the same cycle
        if (sl_ack) begin
          if (rnw_q) rdata_d = sl_data;
          state_d = StAck;
        end else if (expired) begin
          rdata_d = C_ERR_DATA[C_DWIDTH-1:0];
          err_d   = 1'b1;
          state_d = StAck;
        end
      end
      StAck:   state_d = StGap;
      // CS is ignored here so a lingering CS cannot relaunch the access
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      rnw_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      rnw_q   <= rnw_d;
      err_q   <= err_d;
    end
  end

  assign in_ack       = (state_q == StAck);
  assign xbs_select   = (state_q == StReq);
  assign xbs_addr     = addr_q;
  assign xbs_data     = wdata_q;
  assign xbs_rnw      = rnw_q;
  assign xbs_be       = be_q;
  assign IP2Bus_RdAck = in_ack & rnw_q;
  assign IP2Bus_WrAck = in_ack & ~rnw_q;
  assign IP2Bus_Data  = (in_ack && rnw_q) ? rdata_q : '0;
  assign IP2Bus_Error = in_ack & err_q;

endmodule

// File: tb/tb_xbus_slaveif.sv
// Self-checking bench for xbus_slaveif: transaction-level model plus directed literal checks.
module tb_xbus_slaveif;

  localparam int unsigned TO  = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst, cs, rnw, sl_ack;
  logic [31:0] addr, wdata, sl_data;
  logic [3:0]  be;
  logic [31:0] ip_data, x_addr, x_data;
  logic        rdack, wrack, ip_err, x_sel, x_rnw;
  logic [3:0]  x_be;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  xbus_slaveif #(
    .C_DWIDTH         (32),
    .C_TIMEOUT_CYCLES (TO),
    .C_ERR_DATA       (ERR)
  ) dut (
    .Bus2IP_Clk   (clk),
    .Bus2IP_Reset (rst),
    .Bus2IP_CS    (cs),
    .Bus2IP_RNW   (rnw),
    .Bus2IP_Addr  (addr),
    .Bus2IP_Data  (wdata),
    .Bus2IP_BE    (be),
    .IP2Bus_Data  (ip_data),
    .IP2Bus_RdAck (rdack),
    .IP2Bus_WrAck (wrack),
    .IP2Bus_Error (ip_err),
    .xbs_select   (x_sel),
    .xbs_addr     (x_addr),
    .xbs_data     (x_data),
    .xbs_rnw      (x_rnw),
    .xbs_be       (x_be),
    .sl_ack       (sl_ack),
    .sl_data      (sl_data)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one access is "requesting" until acked or timed out,
  // then one ack cycle, then one dead cycle.
  bit          m_req, m_ack, m_gap, m_rnw, m_err;
  int          m_req_cycles;
  logic [31:0] m_byte_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  always @(posedge clk) begin
    if (rst) begin
      m_req = 0; m_ack = 0; m_gap = 0; m_rnw = 0; m_err = 0;
      m_byte_addr = 0; m_wdata = 0; m_rdata = 0; m_be = 0; m_req_cycles = 0;
    end else if (m_ack) begin
      m_ack = 0;
      m_gap = 1;
    end else if (m_gap) begin
      m_gap = 0;
    end else if (m_req) begin
      m_req_cycles++;
      if (sl_ack) begin
        if (m_rnw) m_rdata = sl_data;
        m_req = 0;
        m_ack = 1;
      end
`ifdef XBUS_SLAVEIF_TIMEOUT_EN
      else if (m_req_cycles == TO) begin
        m_rdata = ERR;
        m_err   = 1;
        m_req   = 0;
        m_ack   = 1;
      end
`endif
    end else if (cs) begin
      m_req = 1; m_req_cycles = 0; m_err = 0;
      m_byte_addr = addr; m_wdata = wdata; m_be = be; m_rnw = rnw;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk1 ("m_select", x_sel, m_req);
      chk32("m_xaddr", x_addr, m_byte_addr / 4);
      chk32("m_xdata", x_data, m_wdata);
      chk1 ("m_xrnw", x_rnw, m_rnw);
      chk32("m_xbe", {28'b0, x_be}, {28'b0, m_be});
      chk1 ("m_rdack", rdack, m_ack && m_rnw);
      chk1 ("m_wrack", wrack, m_ack && !m_rnw);
      chk32("m_ipdata", ip_data, (m_ack && m_rnw) ? m_rdata : 32'h0);
      chk1 ("m_error", ip_err, m_ack && m_err);
    end
  end

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; cs = 0; rnw = 0; addr = 0; wdata = 0; be = 0; sl_ack = 0; sl_data = 0;
    nxt; nxt;
    rst = 0;
    chk_en = 1;
    chk1 ("rst_select", x_sel, 1'b0);
    chk32("rst_xaddr", x_addr, 32'h0);
    chk1 ("rst_ack", rdack | wrack | ip_err, 1'b0);

    // Write with ack in the 3rd REQ cycle
    cs = 1; rnw = 0; addr = 32'h10; wdata = 32'hA5A5_1234; be = 4'hF;
    nxt;
    chk1 ("t1_select", x_sel, 1'b1);
    chk32("t1_xaddr", x_addr, 32'h4);
    chk32("t1_xdata", x_data, 32'hA5A5_1234);
    chk1 ("t1_xrnw", x_rnw, 1'b0);
    nxt; nxt;
    sl_ack = 1;
    nxt;
    sl_ack = 0; cs = 0;
    chk1("t1_wrack", wrack, 1'b1);
    chk1("t1_rdack", rdack, 1'b0);
    nxt;
    chk1("t1_wrack_off", wrack, 1'b0);
    nxt;

    // Read, then stray acks in GAP and IDLE
    cs = 1; rnw = 1; addr = 32'h20;
    nxt;
    chk32("t2_xaddr", x_addr, 32'h8);
    chk1 ("t2_xrnw", x_rnw, 1'b1);
    chk32("t2_data_pre", ip_data, 32'h0);
    sl_ack = 1; sl_data = 32'hCAFE_F00D;
    nxt;
    sl_ack = 0; sl_data = 0; cs = 0;
    chk1 ("t2_rdack", rdack, 1'b1);
    chk32("t2_data", ip_data, 32'hCAFE_F00D);
    chk1 ("t2_wrack", wrack, 1'b0);
    nxt;
    sl_ack = 1;
    chk1 ("t2_rdack_off", rdack, 1'b0);
    chk32("t2_data_off", ip_data, 32'h0);
    nxt;
    chk1("t6_gap_stray", rdack | wrack | x_sel, 1'b0);
    nxt;
    sl_ack = 0;
    chk1("t6_idle_stray", rdack | wrack | x_sel, 1'b0);

    // Read with no ack; CS dropped during REQ
    cs = 1; rnw = 1; addr = 32'h40;
    nxt;
    cs = 0;
    for (int i = 2; i <= TO; i++) nxt;
    chk1("t3_select_last", x_sel, 1'b1);
    nxt;
`ifdef XBUS_SLAVEIF_TIMEOUT_EN
    chk1 ("t3_to_rdack", rdack, 1'b1);
    chk1 ("t3_to_error", ip_err, 1'b1);
    chk32("t3_to_data", ip_data, ERR);
`else
    chk1("t3_wait_select", x_sel, 1'b1);
    chk1("t3_wait_noack", rdack | ip_err, 1'b0);
    sl_ack = 1; sl_data = 32'h1234_5678;
    nxt;
    sl_ack = 0;
    chk1 ("t3_late_rdack", rdack, 1'b1);
    chk32("t3_late_data", ip_data, 32'h1234_5678);
`endif
    nxt; nxt;

    // Ack in the expiry cycle wins
    cs = 1; rnw = 1; addr = 32'h44;
    nxt;
    cs = 0;
    for (int i = 2; i <= TO; i++) nxt;
    sl_ack = 1; sl_data = 32'h0BAD_C0DE;
    nxt;
    sl_ack = 0;
    chk1 ("t3b_rdack", rdack, 1'b1);
    chk1 ("t3b_error", ip_err, 1'b0);
    chk32("t3b_data", ip_data, 32'h0BAD_C0DE);
    nxt; nxt;

    // CS held two cycles past the ack must not relaunch
    cs = 1; rnw = 0; addr = 32'h100; wdata = 32'h5555_AAAA; be = 4'h3;
    nxt;
    sl_ack = 1;
    nxt;
    sl_ack = 0;
    chk1("t4_wrack", wrack, 1'b1);
    nxt;
    chk1("t4_gap_select", x_sel, 1'b0);
    nxt;
    cs = 0;
    chk1("t4_idle_select", x_sel, 1'b0);
    nxt;
    chk1("t4_idle2_select", x_sel, 1'b0);
    cs = 1;
    nxt;
    chk1 ("t4_new_select", x_sel, 1'b1);
    chk32("t4_new_be", {28'b0, x_be}, 32'h3);
    sl_ack = 1;
    nxt;
    sl_ack = 0; cs = 0;
    nxt; nxt;

    // Reset during REQ, late ack ignored, then a normal access
    cs = 1; rnw = 1; addr = 32'h200;
    nxt;
    rst = 1;
    nxt;
    rst = 0; cs = 0;
    chk1 ("t5_select", x_sel, 1'b0);
    chk32("t5_xaddr", x_addr, 32'h0);
    sl_ack = 1; sl_data = 32'hFFFF_FFFF;
    nxt;
    sl_ack = 0;
    chk1("t5_late_ack", rdack | wrack, 1'b0);
    cs = 1; rnw = 1; addr = 32'h20;
    nxt;
    chk32("t5_xaddr2", x_addr, 32'h8);
    sl_ack = 1; sl_data = 32'h1357_2468;
    nxt;
    sl_ack = 0; cs = 0;
    chk32("t5_data2", ip_data, 32'h1357_2468);
    nxt; nxt;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      nxt;
      rst     = ($urandom_range(0, 199) == 0);
      cs      = ($urandom_range(0, 2) != 0);
      rnw     = $urandom_range(0, 1);
      addr    = $urandom;
      wdata   = $urandom;
      be      = 4'($urandom_range(0, 15));
      sl_ack  = ($urandom_range(0, 3) == 0);
      sl_data = $urandom;
    end
    nxt;
    rst = 0; cs = 0; sl_ack = 0;
    nxt;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
